tx_frame_serializer: RTL

Downstream stage of the TX input register. On a start pulse it snapshots the 136-bit assembled packet (header + up to 15 payload bytes) and the test-mode flag. It then emits the frame MSB-first on a single serial line as header byte, Length payload bytes, then one CRC-8 byte. It feeds the link/channel model and the RX side; test mode deliberately corrupts the CRC so the receiver's error detection can be exercised.

---
 rtl/tx_frame_serializer_if.sv | 23 ++
 rtl/tx_frame_serializer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tx_frame_serializer_if.sv
// Handshake and data bundle between the TX input register and the frame serializer.
// The master side drives the packet and start request; the slave side returns the serial line and status.
interface tx_frame_serializer_if;
    logic         start;
    logic         packet_ready;
    logic [135:0] tx_packet;
    logic         test_mode;
    logic         tx_serial;
    logic         tx_valid;
    logic         busy;
    logic         done;
    logic [7:0]   crc_out;

    modport master (
        output start, packet_ready, tx_packet, test_mode,
        input  tx_serial, tx_valid, busy, done, crc_out
    );

    modport slave (
        input  start, packet_ready, tx_packet, test_mode,
        output tx_serial, tx_valid, busy, done, crc_out
    );
endinterface

// File: rtl/tx_frame_serializer.sv
// Serialises a latched packet MSB-first: header, L payload bytes, then a CRC-8 byte.
// Test mode flips CRC bit 0 so the receiver's error detection can be exercised.
module tx_frame_serializer #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter logic [7:0]  CRC_POLY     = 8'h07,
    parameter logic [7:0]  CRC_INIT     = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    tx_frame_serializer_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CRC, S_FINISH} state_t;

    localparam logic [7:0] TICK_LAST = 8'(CLKS_PER_BIT - 1);

    state_t       r_state;
    logic [135:0] r_packet;
    logic         r_test_mode;
    logic [7:0]   r_crc;
    logic [7:0]   r_crc_out;
    logic [7:0]   r_tick;
    logic [2:0]   r_bit_cnt;
    logic [3:0]   r_byte_cnt;
    logic         r_tx_serial;
    logic         r_tx_valid;
    logic         r_busy;
    logic         r_done;

    logic [7:0]   w_payload [16];
    logic [3:0]   w_len;
    logic [7:0]   w_crc_next;
    logic [7:0]   w_crc_sent;
    logic [7:0]   w_crc_enter;
    logic [7:0]   w_cur_byte;
    logic         w_bit_end;
    logic         w_accept;

    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_payload
            assign w_payload[gi] = r_packet[127 - 8*gi -: 8];
        end
    endgenerate

    assign w_len       = r_packet[131:128];
    assign w_bit_end   = (r_tick == TICK_LAST);
    assign w_crc_next  = crc_step(r_crc, r_tx_serial);
    // r_crc is frozen during the CRC byte, so the sent value can be derived on the fly.
    assign w_crc_sent  = r_crc ^ {7'b0, r_test_mode};
    assign w_crc_enter = w_crc_next ^ {7'b0, r_test_mode};
    assign w_accept    = bus.start && bus.packet_ready &&
                         (r_state == S_IDLE || r_state == S_FINISH);

    always_comb begin
        w_cur_byte = w_crc_sent;
        if (r_state == S_HEADER)
            w_cur_byte = r_packet[135:128];
        else if (r_state == S_PAYLOAD)
            w_cur_byte = w_payload[r_byte_cnt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_packet    <= '0;
            r_test_mode <= 1'b0;
            r_crc       <= 8'h00;
            r_crc_out   <= 8'h00;
            r_tick      <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 4'd0;
            r_tx_serial <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_packet    <= bus.tx_packet;
                r_test_mode <= bus.test_mode;
                r_crc       <= CRC_INIT;
                r_tick      <= 8'h00;
                r_bit_cnt   <= 3'd0;
                r_byte_cnt  <= 4'd0;
                r_tx_serial <= bus.tx_packet[135];
                r_tx_valid  <= 1'b1;
                r_busy      <= 1'b1;
                r_state     <= S_HEADER;
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_FINISH: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_HEADER, S_PAYLOAD, S_CRC: begin
                        if (!w_bit_end) begin
                            r_tick <= r_tick + 8'd1;
                        end else begin
                            r_tick <= 8'h00;
                            if (r_state != S_CRC)
                                r_crc <= w_crc_next;
                            if (r_bit_cnt != 3'd7) begin
                                r_bit_cnt   <= r_bit_cnt + 3'd1;
                                r_tx_serial <= w_cur_byte[3'd6 - r_bit_cnt];
                            end else begin
                                r_bit_cnt <= 3'd0;
                                if (r_state == S_HEADER && w_len != 4'd0) begin
                                    r_state     <= S_PAYLOAD;
                                    r_byte_cnt  <= 4'd0;
                                    r_tx_serial <= w_payload[0][7];
                                end else if (r_state == S_PAYLOAD && r_byte_cnt != w_len - 4'd1) begin
                                    r_byte_cnt  <= r_byte_cnt + 4'd1;
                                    r_tx_serial <= w_payload[r_byte_cnt + 4'd1][7];
                                end else if (r_state != S_CRC) begin
                                    r_state     <= S_CRC;
                                    r_tx_serial <= w_crc_enter[7];
                                end else begin
                                    r_state     <= S_FINISH;
                                    r_tx_serial <= 1'b0;
                                    r_tx_valid  <= 1'b0;
                                    r_done      <= 1'b1;
                                    r_crc_out   <= w_crc_sent;
                                end
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.tx_serial = r_tx_serial;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.crc_out   = r_crc_out;
endmodule
